// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate pipeline: FSM state encoding,
// accumulator saturation limits and parameter legality checks.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } mac_state_e;

    localparam int MAX_ACC_W = 128;

    // Largest positive value of an acc_w-bit signed number, in a 128-bit container.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int acc_w);
        logic [MAX_ACC_W-1:0] one;
        one = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
        return (one << (acc_w - 1)) - one;
    endfunction

    // Most negative acc_w-bit value; the low acc_w bits of the complement of sat_max.
    function automatic logic [MAX_ACC_W-1:0] sat_min(input int acc_w);
        return ~sat_max(acc_w);
    endfunction

    function automatic bit params_ok(input int data_w, input int acc_w, input int mul_lat);
        return (data_w >= 8) && (data_w <= 64) &&
               (acc_w >= 2 * data_w) && (acc_w <= MAX_ACC_W) &&
               (mul_lat >= 1) && (mul_lat <= 6);
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Signed DATA_W x DATA_W multiplier, MUL_LAT register stages deep, carrying a
// valid bit and a stream-last tag alongside every stage; clear empties it.
module mac_mult_pipe #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic                       out_valid,
    output logic                       out_last,
    output logic signed [2*DATA_W-1:0] product,
    output logic                       busy
);

    logic [MUL_LAT-1:0]         vld_q;
    logic [MUL_LAT-1:0]         last_q;
    logic signed [2*DATA_W-1:0] prod_q [MUL_LAT];
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;

    assign a_ext = (2*DATA_W)'(a);
    assign b_ext = (2*DATA_W)'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (clear) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            last_q[0] <= in_valid && in_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    // NOTE: product registers carry no reset; the reset valid bits already mark them as garbage.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            prod_q[0] <= a_ext * b_ext;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign out_valid = vld_q[MUL_LAT-1];
    assign out_last  = last_q[MUL_LAT-1];
    assign product   = prod_q[MUL_LAT-1];
    assign busy      = |vld_q;

endmodule

// File: rtl/mac_accum_pipe.sv
// Streaming signed multiply-accumulate: sums products of a stream and hands out
// one result per stream. Define MAC_ACCUM_SAT_EN to saturate instead of wrap.
module mac_accum_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 80,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     last,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_overflow,
    output logic                     busy
);

    if (!params_ok(DATA_W, ACC_W, MUL_LAT)) begin : g_param_check
        $error("mac_accum_pipe: illegal DATA_W/ACC_W/MUL_LAT combination");
    end

    mac_state_e state_q;
    mac_state_e state_d;

    logic                       accept;
    logic                       p_valid;
    logic                       p_last;
    logic                       pipe_busy;
    logic signed [2*DATA_W-1:0] p_data;
    logic signed [ACC_W-1:0]    p_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       ovf_q;
    logic                       add_ovf;
    logic                       finish;

    // clear wins over everything, so it also blocks acceptance in its own cycle.
    assign in_ready = (state_q == ST_ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

    mac_mult_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (accept),
        .in_last   (last),
        .a         (a),
        .b         (b),
        .out_valid (p_valid),
        .out_last  (p_last),
        .product   (p_data),
        .busy      (pipe_busy)
    );

    assign p_ext   = ACC_W'(p_data);
    assign acc_sum = acc_q + p_ext;
    assign add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_ACCUM_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    // Both addends share a sign on overflow, so the product sign picks the rail.
    always_comb begin
        acc_next = acc_sum;
        if (add_ovf) begin
            acc_next = p_ext[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign acc_next = acc_sum;
`endif

    // The youngest product of a stream carries the last tag; when it lands the stream is done.
    assign finish = p_valid && p_last && (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: if (accept && last) state_d = ST_DRAIN;
            ST_DRAIN: if (finish)         state_d = ST_HOLD;
            ST_HOLD:  if (out_ready)      state_d = ST_ACCUM;
            default:                      state_d = ST_ACCUM;
        endcase
        if (clear) begin
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (finish) begin
                out_data     <= acc_next;
                out_overflow <= ovf_q | add_ovf;
                acc_q        <= '0;
                ovf_q        <= 1'b0;
            end else if (p_valid) begin
                acc_q <= acc_next;
                ovf_q <= ovf_q | add_ovf;
            end
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = pipe_busy || (state_q != ST_ACCUM);

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Self-checking bench for mac_accum_pipe: directed corner cases plus random
// streams compared against an exact-arithmetic reference model.
module tb_mac_accum_pipe;

    localparam int DATA_W  = 32;
    localparam int ACC_W   = 64;
    localparam int MUL_LAT = 3;

    localparam logic signed [127:0] MAXV = (128'sd1 <<< (ACC_W - 1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (ACC_W - 1));

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a = '0;
    logic signed [DATA_W-1:0] b = '0;
    logic                     last = 1'b0;
    logic                     clear = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_overflow;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic signed [DATA_W-1:0] qa[$];
    logic signed [DATA_W-1:0] qb[$];

    mac_accum_pipe #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .last         (last),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact sum of products, with overflow judged against the ACC_W signed range.
    function automatic void model(output logic signed [ACC_W-1:0] res, output logic ovf);
        logic signed [127:0]     acc;
        logic signed [127:0]     sum;
        logic signed [ACC_W-1:0] wrapped;
        acc = '0;
        ovf = 1'b0;
        for (int i = 0; i < qa.size(); i++) begin
            sum = acc + 128'(qa[i]) * 128'(qb[i]);
            if (sum > MAXV || sum < MINV) begin
                ovf = 1'b1;
`ifdef MAC_ACCUM_SAT_EN
                sum = (sum > MAXV) ? MAXV : MINV;
`else
                wrapped = sum[ACC_W-1:0];
                sum = 128'(wrapped);
`endif
            end
            acc = sum;
        end
        wrapped = acc[ACC_W-1:0];
        res = wrapped;
    endfunction

    function automatic logic signed [DATA_W-1:0] rand_op();
        case ($urandom_range(3))
            0:       return {1'b1, {(DATA_W-1){1'b0}}};
            1:       return {1'b0, {(DATA_W-1){1'b1}}};
            2:       return DATA_W'(int'($urandom_range(0, 31)) - 16);
            default: return DATA_W'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds qa/qb as one stream, checks the result, holds it for `hold` cycles, releases it.
    task automatic run_stream(input string tag, input int gap_pct, input int hold, input bit chk_lat);
        logic signed [ACC_W-1:0] exp_d;
        logic                    exp_o;
        int                      t_acc;
        int                      guard;
        model(exp_d, exp_o);
        t_acc = cyc;
        for (int i = 0; i < qa.size(); i++) begin
            if ($urandom_range(99) < gap_pct) begin
                in_valid  = 1'b0;
                out_ready = 1'(($urandom_range(1)));
                tick();
            end
            guard = 0;
            while (!in_ready && guard < 20) begin
                in_valid = 1'b0;
                tick();
                guard++;
            end
            check({tag, "_in_ready"}, in_ready, 1'b1);
            if (!in_ready) return;
            in_valid  = 1'b1;
            a         = qa[i];
            b         = qb[i];
            last      = (i == qa.size() - 1);
            out_ready = 1'(($urandom_range(1)));
            tick();
            t_acc    = cyc;
            in_valid = 1'b0;
            last     = 1'b0;
        end
        out_ready = 1'b0;
        if (chk_lat) check({tag, "_drain_ready"}, in_ready, 1'b0);
        guard = 0;
        while (!out_valid && guard < 4 * MUL_LAT + 8) begin
            tick();
            guard++;
        end
        check({tag, "_out_valid"}, out_valid, 1'b1);
        if (!out_valid) return;
        if (chk_lat) check({tag, "_latency"}, cyc - t_acc + 1, MUL_LAT + 1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_ovf"}, out_overflow, exp_o);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_data"}, out_data, exp_d);
            check({tag, "_hold_ovf"}, out_overflow, exp_o);
            check({tag, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_ovf", out_overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);

        // Back-to-back three-pair stream
        qa = '{32'sd3, -32'sd4, 32'sd5};
        qb = '{32'sd7, 32'sd2, -32'sd6};
        run_stream("basic", 0, 0, 1'b1);

        // Same stream with a stalled consumer, then an immediate single pair
        run_stream("stall", 0, 5, 1'b1);
        check("stall_next_ready", in_ready, 1'b1);
        qa = '{32'sd1};
        qb = '{32'sd1};
        run_stream("single", 0, 0, 1'b1);

        // Four maximal positive products overflow a 64-bit accumulator
        qa = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        qb = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        run_stream("ovf", 0, 2, 1'b1);

        // Clear flushes products in flight
        in_valid = 1'b1;
        a        = 32'sd100;
        b        = 32'sd100;
        last     = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", busy, 1'b0);
        repeat (4) tick();
        qa = '{-32'sd1};
        qb = '{-32'sd1};
        run_stream("after_clr", 0, 0, 1'b1);

        // Reset during DRAIN discards the pending result
        in_valid = 1'b1;
        a        = 32'sd5;
        b        = 32'sd7;
        last     = 1'b0;
        tick();
        a    = 32'sd6;
        b    = 32'sd8;
        last = 1'b1;
        tick();
        in_valid = 1'b0;
        last     = 1'b0;
        tick();
        check("drain_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_ovf", out_overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rst_in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);

        // clear coinciding with a last pair: nothing accepted, nothing produced
        clear    = 1'b1;
        in_valid = 1'b1;
        a        = 32'sd9;
        b        = 32'sd9;
        last     = 1'b1;
        #1;
        check("clr_last_ready", in_ready, 1'b0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        last     = 1'b0;
        check("clr_last_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("clr_last_no_result", seen, 0);

        // Random streams with gaps, stalls and stray out_ready
        for (int s = 0; s < 25; s++) begin
            int len;
            len = $urandom_range(1, 6);
            qa.delete();
            qb.delete();
            for (int i = 0; i < len; i++) begin
                qa.push_back(rand_op());
                qb.push_back(rand_op());
            end
            run_stream($sformatf("rnd%0d", s), 30, $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accum_pipe.md
MAC_ACCUM_PIPE -- requirements
Module: mac_accum_pipe

Interface
REQ-001 Parameter DATA_W, default 32: signed operand width, valid range 8..64.
REQ-002 Parameter ACC_W, default 80: signed accumulator and result width, valid range 2*DATA_W..128.
REQ-003 Parameter MUL_LAT, default 3: multiplier pipeline depth in cycles, valid range 1..6.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 in_valid  input  1: operand pair a/b/last is valid.
REQ-007 in_ready  output  1: block accepts an operand pair this cycle.
REQ-008 a, b  input  DATA_W each: signed operands.
REQ-009 last  input  1: the accepted pair is the final pair of the current stream.
REQ-010 clear  input  1: synchronous abort; flushes the pipeline and the accumulator.
REQ-011 out_valid  output  1: out_data/out_overflow hold a completed stream result.
REQ-012 out_ready  input  1: consumer accepts the result.
REQ-013 out_data  output  ACC_W: signed stream sum of products.
REQ-014 out_overflow  output  1: signed overflow occurred during the stream.
REQ-015 busy  output  1: high when any product is in flight or the state is not ACCUM.

Function
REQ-016 A pair SHALL be accepted iff in_valid && in_ready.
REQ-017 Each accepted product SHALL be sign-extended to ACC_W and added to the accumulator exactly MUL_LAT cycles after acceptance; full throughput is one pair per cycle.
REQ-018 FSM states SHALL be ACCUM, DRAIN and HOLD; in_ready = 1 only in ACCUM.
REQ-019 ACCUM->DRAIN on acceptance with last=1.
REQ-020 DRAIN->HOLD when the last product is added: the register holding out_data SHALL take the final sum (including that product), out_valid=1, and the accumulator and overflow flag SHALL clear to 0 in the same cycle.
REQ-021 Latency from acceptance of last to out_valid=1 SHALL be MUL_LAT+1 cycles.
REQ-022 HOLD->ACCUM on out_ready=1; out_data and out_overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 out_ready while out_valid=0 SHALL be ignored.
REQ-024 Overflow detection: an addition with equal operand signs and a differing result sign SHALL set the sticky stream overflow flag.
REQ-025 clear=1 SHALL have priority over all other inputs in every state: it invalidates in-flight products, zeroes the accumulator and overflow flag, sets out_valid=0 and moves to ACCUM; no pair is accepted in that cycle.
REQ-026 A single-pair stream (last=1 on the first pair) SHALL produce a result equal to that product.

Reset
REQ-027 While rst_n=0, the block SHALL force the following: state=ACCUM, accumulator=0, pipeline valid bits=0, out_data=0, out_overflow=0, out_valid=0, busy=0.
REQ-028 in_ready SHALL be 1 from the first rising clk edge after rst_n deasserts.
REQ-029 Reset asserted mid-stream or in HOLD SHALL discard all partial and pending results.

Configuration
REQ-030 Macro MAC_ACCUM_SAT_EN defined: on overflow, the accumulator SHALL saturate to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to the operand sign, and out_overflow SHALL still be set.
REQ-031 MAC_ACCUM_SAT_EN undefined: the accumulator SHALL wrap modulo 2^ACC_W, and out_overflow SHALL be set.

Structure
REQ-032 Package mac_pkg SHALL hold the FSM state enum, the saturation-limit constant functions and the parameter range checks.
REQ-033 Sub-module mac_mult_pipe SHALL provide the signed DATA_W x DATA_W multiplier with MUL_LAT stages and a valid bit per stage, flushed by clear.
REQ-034 The accumulator, overflow logic and FSM SHALL reside in mac_accum_pipe.

Verification (DATA_W=32, ACC_W=80, MUL_LAT=3 unless stated)
REQ-035 a={3,-4,5}, b={7,2,-6}, last on the third pair, back-to-back -> out_data=-17, out_valid 4 cycles after the third acceptance, out_overflow=0.
REQ-036 Same stream with out_ready=0 for 5 cycles -> out_data=-17 stable, in_ready=0 throughout; after the out_ready pulse, a new pair a=1, b=1, last is accepted next cycle -> out_data=1.
REQ-037 ACC_W=64, four pairs a=b=-2^31 -> without the macro, out_data=0, out_overflow=1; with MAC_ACCUM_SAT_EN, out_data=2^63-1, out_overflow=1.
REQ-038 Two pairs 100x100 accepted, then clear=1 -> busy=0 within 1 cycle; next stream a=-1, b=-1, last -> out_data=1.
REQ-039 rst_n pulsed low during DRAIN -> all outputs 0 immediately, no out_valid afterwards, in_ready=1 after release.
REQ-040 Simultaneous clear=1 and in_valid=1 with last=1 in ACCUM -> pair not accepted, no result produced.
